btn_debounce_bank: RTL and testbench
====================================

Name: btn_debounce_bank

Overview:
- Parametrised N-channel successor to the single-button conditioner.
- Per channel: 2-flop synchroniser, then a bidirectional debounce with symmetric press and release filtering.
- Outputs per channel: clean level, one-cycle press and release pulses, and a one-shot long-press pulse.
- Sits between raw board buttons/switches and UI/control FSMs. One instance serves the whole button bank.

Parameters:
- N, 4, number of independent channels (>=1).
- COUNT, 5, debounce counter width; a synced input change must persist 2^COUNT cycles to be accepted.
- LONG_W, 8, hold counter width; long pulse fires 2^LONG_W-1 cycles after the press pulse.
- ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed (inverted before sync); applies to all channels.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  N  raw asynchronous button inputs, bit i = channel i.
- level  out  N  debounced pressed state, 1 = pressed.
- press  out  N  one-cycle pulse when level rises.
- release  out  N  one-cycle pulse when level falls.
- long_press  out  N  one-cycle pulse, once per press, after a sustained hold.
- any_press  out  1  registered OR of press, one cycle later than press.

Behaviour:
- Reset (async assert, sync-free deassert):
  - All outputs, counters and stable states are 0.
  - Sync flops reset to the not-pressed normalised value 0.
- Normalise: n[i] = btn[i] XOR ACTIVE_LOW. Sync chain s0 <= n, s1 <= s0; only s1 feeds the logic.
- Debounce per channel (ctr COUNT bits, stable 1 bit):
  - s1 == stable: ctr <= 0.
  - s1 != stable and ctr != all-ones: ctr <= ctr+1.
  - s1 != stable and ctr == all-ones: stable <= s1, ctr <= 0.
  - Any single-cycle agreement with stable restarts the count.
- Latency: if btn changes before edge k and stays stable, level changes at edge k+1+2^COUNT. Example: COUNT=3 gives level at edge k+9.
- level = stable, driven directly from the flop.
- press / release:
  - Registered, asserted at the same edge that stable flips (press on 0->1, release on 1->0).
  - High for exactly one cycle. Never both high on one channel.
- Hold counter per channel (LONG_W bits):
  - Cleared at the press edge.
  - While level=1 and hold != all-ones: hold++. Saturates at all-ones and stays until release.
  - long_press pulses at the edge where hold goes all-ones-minus-1 -> all-ones, i.e. 2^LONG_W-1 edges after the press edge.
  - Cleared at the release edge.
  - If release and saturation would fall on the same edge, release wins: no long_press, hold <= 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses. any_press = OR of the previous cycle's press.
- Reset mid-operation:
  - All pulses, counters and levels clear immediately.
  - A button held through reset must re-qualify: after rst_n rises it needs the full 2+2^COUNT latency, then press fires.
- No other state. No combinational path from btn to any output.

Test Plan:
- Reset/idle (N=4, COUNT=3, LONG_W=4): hold rst_n=0 with btn=4'hF -> all outputs 0; release rst_n -> level=4'hF and press=4'hF both rise together exactly 10 edges after rst_n deasserts, press high 1 cycle, any_press high the following cycle.
- Bounce rejection: ch0 toggles every 3 cycles for 40 cycles, then holds 1 -> no press during bouncing; press[0] exactly 9 edges after the last change is synced (edge k+9); other channels stay silent.
- Release filtering: ch1 pressed and stable, then 1-cycle low glitches every 5 cycles -> level[1] stays 1, no release; a sustained low -> release[1] pulse at k+9 and level[1] falls on the same edge.
- Long press: ch2 held -> long_press[2] exactly 15 edges after press[2], exactly once even when held 100 cycles; a second press/release cycle gives another long_press.
- Release at saturation: ch3 release timed so its level falls on the edge hold would saturate -> release[3]=1, long_press[3]=0; a short press of 5 cycles -> no long_press.
- ACTIVE_LOW=1 build plus mid-operation reset: btn=0 is pressed -> press fires; pulse rst_n low for 1 cycle during a hold count -> outputs clear async, and press and long_press re-sequence from scratch.

Source files
------------

// File: rtl/btn_debounce_bank.sv
// N-channel button conditioner: per-channel 2-flop synchroniser, symmetric
// press/release debounce, one-cycle press/release pulses and a one-shot
// long-press pulse. One instance serves a whole button bank.
// The release pulse port is named release_pulse because 'release' is a
// reserved word in SystemVerilog.
module btn_debounce_bank #(
  parameter int unsigned N          = 4,
  parameter int unsigned COUNT      = 5,
  parameter int unsigned LONG_W     = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press,
  output logic         any_press
);

  localparam logic [COUNT-1:0]  CtrMax  = '1;
  localparam logic [LONG_W-1:0] HoldMax = '1;
  localparam logic [LONG_W-1:0] HoldPre = HoldMax - LONG_W'(1);

  logic [N-1:0]      btn_norm;
  logic [N-1:0]      sync0_q, sync1_q;
  logic [N-1:0]      stable_q, stable_d;
  logic [COUNT-1:0]  ctr_q [N];
  logic [COUNT-1:0]  ctr_d [N];
  logic [LONG_W-1:0] hold_q [N];
  logic [LONG_W-1:0] hold_d [N];
  logic [N-1:0]      press_q, press_d;
  logic [N-1:0]      release_q, release_d;
  logic [N-1:0]      long_q, long_d;
  logic              any_q;

  // Normalise so that 1 always means pressed.
  assign btn_norm = btn ^ {N{ACTIVE_LOW}};

  // Two-flop synchroniser; resets to the not-pressed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= btn_norm;
      sync1_q <= sync0_q;
    end
  end

  // Debounce, edge pulses and hold counter next-state, per channel.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ctr_d[i]  = '0;
      hold_d[i] = hold_q[i];
      if (sync1_q[i] != stable_q[i]) begin
        if (ctr_q[i] == CtrMax) begin
          stable_d[i]  = sync1_q[i];
          press_d[i]   = sync1_q[i];
          release_d[i] = ~sync1_q[i];
        end else begin
          ctr_d[i] = ctr_q[i] + COUNT'(1);
        end
      end
      // A level edge clears the hold count; release therefore beats saturation.
      if (press_d[i] || release_d[i]) begin
        hold_d[i] = '0;
      end else if (stable_q[i] && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + LONG_W'(1);
        long_d[i] = (hold_q[i] == HoldPre);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      any_q     <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        ctr_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      any_q     <= |press_q;
      for (int unsigned i = 0; i < N; i++) begin
        ctr_q[i]  <= ctr_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign level         = stable_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign any_press     = any_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: N=4, COUNT=3, LONG_W=4.
// Instance a is active-high, instance b is active-low.
module tb_btn_debounce_bank;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] btn_a, btn_b;
  logic [3:0] level_a, press_a, rel_a, long_a;
  logic [3:0] level_b, press_b, rel_b, long_b;
  logic       any_a, any_b;

  int n_total = 0;
  int n_pass  = 0;

  int press_cnt [4];
  int rel_cnt   [4];
  int long_cnt  [4];

  btn_debounce_bank #(.N(4), .COUNT(3), .LONG_W(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_a),
    .btn           (btn_a),
    .level         (level_a),
    .press         (press_a),
    .release_pulse (rel_a),
    .long_press    (long_a),
    .any_press     (any_a)
  );

  btn_debounce_bank #(.N(4), .COUNT(3), .LONG_W(4), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_b),
    .btn           (btn_b),
    .level         (level_b),
    .press         (press_b),
    .release_pulse (rel_b),
    .long_press    (long_b),
    .any_press     (any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for instance a, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
      long_cnt[i]  = 0;
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (press_a[i]) press_cnt[i] <= press_cnt[i] + 1;
      if (rel_a[i])   rel_cnt[i]   <= rel_cnt[i] + 1;
      if (long_a[i])  long_cnt[i]  <= long_cnt[i] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic logic [3:0] pick(input int dut, input int kind);
    if (dut == 0) begin
      case (kind)
        0:       return press_a;
        1:       return rel_a;
        default: return long_a;
      endcase
    end else begin
      case (kind)
        0:       return press_b;
        1:       return rel_b;
        default: return long_b;
      endcase
    end
  endfunction

  // Ticks until the chosen pulse is seen on channel ch; n = ticks taken, -1 on timeout.
  task automatic wait_pulse(input int dut, input int kind, input int ch, input int budget,
                            output int n);
    logic [3:0] v;
    n = -1;
    for (int t = 1; t <= budget && n < 0; t++) begin
      tick();
      v = pick(dut, kind);
      if (v[ch]) n = t;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    int         adv;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
    logic       any;
  } vec_t;

  vec_t tab [11];

  initial begin
    int n;
    int p0 [4];
    int r0 [4];
    int l0 [4];
    logic acc;
    logic lvl_ok;

    // Button held through reset, then released; edges counted from rst_n rising.
    tab[0]  = '{1'b0, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tab[1]  = '{1'b1, 4'hF,  9, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 9
    tab[2]  = '{1'b1, 4'hF,  1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};  // edge 10: press
    tab[3]  = '{1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};  // edge 11: any_press
    tab[4]  = '{1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 12
    tab[5]  = '{1'b1, 4'hF, 12, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 24
    tab[6]  = '{1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0};  // edge 25: long
    tab[7]  = '{1'b1, 4'hF,  1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 26
    tab[8]  = '{1'b1, 4'h0,  9, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 35
    tab[9]  = '{1'b1, 4'h0,  1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};  // edge 36: release
    tab[10] = '{1'b1, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};  // edge 37

    rst_a = 1'b1;
    rst_b = 1'b1;
    btn_a = 4'hF;
    btn_b = 4'hF;
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int v = 0; v < 11; v++) begin
      rst_a = tab[v].rst;
      btn_a = tab[v].btn;
      for (int c = 0; c < tab[v].adv; c++) tick();
      check($sformatf("vec%0d level", v), level_a, tab[v].lvl);
      check($sformatf("vec%0d press", v), press_a, tab[v].prs);
      check($sformatf("vec%0d release", v), rel_a, tab[v].rel);
      check($sformatf("vec%0d long", v), long_a, tab[v].lng);
      check($sformatf("vec%0d any", v), any_a, tab[v].any);
    end
    rst_b = 1'b1;
    repeat (3) tick();

    // Bounce rejection on ch0.
    for (int i = 0; i < 4; i++) begin
      p0[i] = press_cnt[i];
      r0[i] = rel_cnt[i];
    end
    acc = 1'b0;
    for (int t = 0; t < 39; t++) begin
      if (t % 3 == 0) btn_a[0] = ~btn_a[0];
      tick();
      acc = acc | press_a[0] | rel_a[0] | level_a[0];
    end
    check("bounce quiet", acc, 0);
    wait_pulse(0, 0, 0, 20, n);
    check("bounce press latency", n, 7);
    check("bounce others press", press_cnt[1] + press_cnt[2] + press_cnt[3]
          - p0[1] - p0[2] - p0[3], 0);
    check("bounce others release", rel_cnt[1] + rel_cnt[2] + rel_cnt[3]
          - r0[1] - r0[2] - r0[3], 0);
    btn_a[0] = 1'b0;
    wait_pulse(0, 1, 0, 20, n);
    check("ch0 release latency", n, 10);

    // Release filtering on ch1.
    btn_a[1] = 1'b1;
    wait_pulse(0, 0, 1, 20, n);
    check("ch1 press latency", n, 10);
    r0[1] = rel_cnt[1];
    lvl_ok = 1'b1;
    for (int g = 0; g < 6; g++) begin
      btn_a[1] = 1'b0;
      tick();
      lvl_ok = lvl_ok & level_a[1];
      btn_a[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        lvl_ok = lvl_ok & level_a[1];
      end
    end
    check("ch1 glitch level", lvl_ok, 1);
    check("ch1 glitch no release", rel_cnt[1] - r0[1], 0);
    btn_a[1] = 1'b0;
    wait_pulse(0, 1, 1, 20, n);
    check("ch1 release latency", n, 10);
    check("ch1 level with release", level_a[1], 0);
    check("ch1 press with release", press_a[1], 0);

    // Long press on ch2, held well past saturation, then a second cycle.
    l0[2] = long_cnt[2];
    btn_a[2] = 1'b1;
    wait_pulse(0, 0, 2, 20, n);
    check("ch2 press latency", n, 10);
    wait_pulse(0, 2, 2, 30, n);
    check("ch2 long latency", n, 15);
    tick();
    check("ch2 long one cycle", long_a[2], 0);
    repeat (100) tick();
    check("ch2 long once", long_cnt[2] - l0[2], 1);
    btn_a[2] = 1'b0;
    wait_pulse(0, 1, 2, 20, n);
    check("ch2 release latency", n, 10);
    btn_a[2] = 1'b1;
    wait_pulse(0, 0, 2, 20, n);
    check("ch2 second press", n, 10);
    wait_pulse(0, 2, 2, 30, n);
    check("ch2 second long latency", n, 15);
    btn_a[2] = 1'b0;
    wait_pulse(0, 1, 2, 20, n);
    check("ch2 second release", n, 10);
    check("ch2 long total", long_cnt[2] - l0[2], 2);

    // Release landing on the saturation edge of ch3.
    l0[3] = long_cnt[3];
    btn_a[3] = 1'b1;
    wait_pulse(0, 0, 3, 20, n);
    check("ch3 press latency", n, 10);
    repeat (5) tick();
    btn_a[3] = 1'b0;
    wait_pulse(0, 1, 3, 20, n);
    check("ch3 release at saturation", n, 10);
    check("ch3 long on release edge", long_a[3], 0);
    repeat (3) tick();
    check("ch3 no long", long_cnt[3] - l0[3], 0);
    // Short press: released right after the press pulse.
    btn_a[3] = 1'b1;
    wait_pulse(0, 0, 3, 20, n);
    check("ch3 short press", n, 10);
    btn_a[3] = 1'b0;
    wait_pulse(0, 1, 3, 20, n);
    check("ch3 short release", n, 10);
    repeat (20) tick();
    check("ch3 short no long", long_cnt[3] - l0[3], 0);

    // Active-low instance: 0 means pressed; reset mid-hold forces re-qualification.
    btn_b[0] = 1'b0;
    wait_pulse(1, 0, 0, 20, n);
    check("al press latency", n, 10);
    check("al level", level_b, 4'h1);
    repeat (5) tick();
    rst_b = 1'b0;
    #1;
    check("al reset level", level_b, 0);
    check("al reset press", press_b, 0);
    check("al reset long", long_b, 0);
    tick();
    rst_b = 1'b1;
    wait_pulse(1, 0, 0, 20, n);
    check("al re-press latency", n, 10);
    check("al other channels", level_b, 4'h1);
    wait_pulse(1, 2, 0, 30, n);
    check("al long latency", n, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
